writeback_drainer: RTL and testbench
====================================

Name: writeback_drainer

Overview:
- Consumer end of the address queue in the writebooster path: pops queued line addresses and turns each into one AXI4 full-line write burst on the master port.
- Sits between the queue outputs (value, empty, full) and the AXI write channels.
- Returns a one-cycle consumed pulse to the queue once the write response is received.
- Exposes completion and error counters to the register file.

Parameters:
- ADDR_WIDTH, 40, width of queued addresses and AWADDR.
- DATA_WIDTH, 128, AXI W data width in bits; a power of two, ≥ REGISTER_SIZE.
- LINE_BYTES, 64, bytes per burst; a multiple of DATA_WIDTH/8.
- REGISTER_SIZE, 32, width of the pattern register and the counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  drainer may start new bursts
- flush  in  1  level; drain until the queue is empty
- pattern  in  REGISTER_SIZE  fill word, replicated across WDATA
- q_value  in  ADDR_WIDTH  head-of-queue address
- q_empty  in  1  queue empty
- q_full  in  1  queue full
- q_consumed  out  1  one-cycle pop strobe to the queue
- m_awaddr  out  ADDR_WIDTH  line-aligned address
- m_awlen  out  8  BEATS-1
- m_awsize  out  3  log2(DATA_WIDTH/8)
- m_awburst  out  2  constant 2'b01 (INCR)
- m_awvalid  out  1  AW valid
- m_awready  in  1  AW ready
- m_wdata  out  DATA_WIDTH  pattern replicated DATA_WIDTH/REGISTER_SIZE times
- m_wstrb  out  DATA_WIDTH/8  all ones
- m_wlast  out  1  last beat
- m_wvalid  out  1  W valid
- m_wready  in  1  W ready
- m_bresp  in  2  write response
- m_bvalid  in  1  B valid
- m_bready  out  1  B ready
- busy  out  1  FSM not in IDLE
- writes_done  out  REGISTER_SIZE  completed bursts
- write_errors  out  REGISTER_SIZE  bursts with bresp[1]=1

Behaviour:
- Derived constant: BEATS = LINE_BYTES*8/DATA_WIDTH.
- Reset (async): FSM=IDLE. All valid/ready/strobe outputs = 0. busy=0. Counters = 0. drain latch = 0. Beat counter = 0. Address and data registers = 0.
- Reset mid-burst: all valids drop immediately. The AXI slave is reset in the same domain.
- drain latch:
  - Set when q_full=1 or flush=1.
  - Cleared in IDLE when q_empty=1 and flush=0.
- FSM states: IDLE, ADDR, DATA, RESP, POP.
- IDLE:
  - If enable & drain & !q_empty and q_value==0: go to POP. The entry is discarded with no bus traffic; 0 is the invalid address.
  - Else if enable & drain & !q_empty: capture addr = q_value with the low log2(LINE_BYTES) bits cleared. Capture pattern. Go to ADDR.
- ADDR:
  - m_awvalid=1, held stable until m_awready.
  - On handshake: go to DATA, beat=0.
- DATA:
  - m_wvalid=1; m_wlast=(beat==BEATS-1).
  - On each W handshake, beat increments.
  - On the handshake with wlast=1: go to RESP.
  - W is not issued before the AW handshake.
- RESP:
  - m_bready=1.
  - On m_bvalid: writes_done+1; if bresp[1]=1, also write_errors+1. Go to POP.
- POP:
  - q_consumed=1 for exactly one cycle, then IDLE.
  - The queue updates empty at that edge, so IDLE samples fresh flags.
- Latency:
  - Minimum IDLE→q_consumed with zero-wait slave: 3+BEATS cycles (ADDR 1, DATA BEATS, RESP 1, POP 1).
  - Back-to-back bursts have one IDLE cycle between them.
- enable deasserted mid-burst: the current burst completes; no new burst starts.
- Counters wrap modulo 2^REGISTER_SIZE.
- q_consumed is never asserted while q_empty=1 in IDLE.

Test Plan:
- Push 0x12_3456_7844 until full, pattern=0xA5A5A5A5, zero-wait slave → awaddr=0x12_3456_7840, awlen=3, awsize=4, 4 beats of 0xA5A5..., wlast on beat 3, one q_consumed per entry, writes_done=4, q_empty=1.
- One entry, no flush, queue not full → no awvalid for 50 cycles. Assert flush → burst issued, q_consumed pulse, drain clears.
- Entry with address 0, flush=1 → q_consumed after 2 cycles, no awvalid, writes_done unchanged.
- awready held low 10 cycles and wready toggling → awaddr/awvalid stable, wvalid held during stalls, exactly 4 W handshakes.
- bresp=2'b10 on two of three bursts → write_errors=2, writes_done=3.
- Assert reset during DATA beat 2 → awvalid/wvalid/q_consumed=0 the same cycle, counters 0. After release with the queue refilled, a burst restarts at beat 0.

Source files
------------

// File: rtl/writeback_drainer.sv
// Drains queued line addresses into AXI4 full-line INCR write bursts filled with a pattern word,
// pops the queue once each burst's write response arrives, and counts completions and errors.
module writeback_drainer #(
  parameter int ADDR_WIDTH    = 40,
  parameter int DATA_WIDTH    = 128,
  parameter int LINE_BYTES    = 64,
  parameter int REGISTER_SIZE = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [REGISTER_SIZE-1:0] pattern,
  input  logic [ADDR_WIDTH-1:0]    q_value,
  input  logic                     q_empty,
  input  logic                     q_full,
  output logic                     q_consumed,
  output logic [ADDR_WIDTH-1:0]    m_awaddr,
  output logic [7:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [DATA_WIDTH-1:0]    m_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_wstrb,
  output logic                     m_wlast,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic                     busy,
  output logic [REGISTER_SIZE-1:0] writes_done,
  output logic [REGISTER_SIZE-1:0] write_errors
);

  localparam int                    BEATS     = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int                    REPL      = DATA_WIDTH / REGISTER_SIZE;
  localparam logic [7:0]            LAST_BEAT = 8'(BEATS - 1);
  localparam logic [2:0]            AW_SIZE   = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, POP} state_t;

  state_t                   state;
  logic                     drain;
  logic [7:0]               beat;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [REGISTER_SIZE-1:0] pattern_q;

  // Only the error bit of the write response is significant here.
  logic unused_bresp_okay;
  assign unused_bresp_okay = m_bresp[0];

  assign m_awaddr  = addr_q;
  assign m_awlen   = LAST_BEAT;
  assign m_awsize  = AW_SIZE;
  assign m_awburst = 2'b01;
  assign m_wdata   = {REPL{pattern_q}};
  assign m_wstrb   = '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      drain        <= 1'b0;
      beat         <= '0;
      addr_q       <= '0;
      pattern_q    <= '0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_wlast      <= 1'b0;
      m_bready     <= 1'b0;
      q_consumed   <= 1'b0;
      busy         <= 1'b0;
      writes_done  <= '0;
      write_errors <= '0;
    end else begin
      // Drain request sticks until the queue has been emptied with no flush pending.
      if (q_full || flush)
        drain <= 1'b1;
      else if (state == IDLE && q_empty)
        drain <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && drain && !q_empty) begin
            busy <= 1'b1;
            if (q_value == '0) begin
              // Address 0 marks an invalid entry: drop it without touching the bus.
              q_consumed <= 1'b1;
              state      <= POP;
            end else begin
              addr_q    <= q_value & LINE_MASK;
              pattern_q <= pattern;
              m_awvalid <= 1'b1;
              state     <= ADDR;
            end
          end
        end
        ADDR: begin
          if (m_awready) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b1;
            m_wlast   <= (LAST_BEAT == 8'd0);
            beat      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (m_wready) begin
            if (m_wlast) begin
              m_wvalid <= 1'b0;
              m_wlast  <= 1'b0;
              m_bready <= 1'b1;
              state    <= RESP;
            end else begin
              beat    <= beat + 8'd1;
              m_wlast <= (beat + 8'd1 == LAST_BEAT);
            end
          end
        end
        RESP: begin
          if (m_bvalid) begin
            m_bready    <= 1'b0;
            writes_done <= writes_done + REGISTER_SIZE'(1);
            if (m_bresp[1])
              write_errors <= write_errors + REGISTER_SIZE'(1);
            q_consumed  <= 1'b1;
            state       <= POP;
          end
        end
        POP: begin
          q_consumed <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_drainer.sv
// Randomised scoreboard bench: a queue model feeds the drainer, an AXI slave model answers it,
// and a monitor checks every burst against the bursts expected from the queued entries.
module tb_writeback_drainer;

  localparam int AW    = 40;
  localparam int DW    = 128;
  localparam int LB    = 64;
  localparam int RS    = 32;
  localparam int BEATS = LB * 8 / DW;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [RS-1:0] pattern = '0;
  logic [AW-1:0] q_value = '0;
  logic          q_empty = 1'b1;
  logic          q_full = 1'b0;
  logic          q_consumed;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid;
  logic          m_awready = 1'b0;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_wlast;
  logic          m_wvalid;
  logic          m_wready = 1'b0;
  logic [1:0]    m_bresp = 2'b00;
  logic          m_bvalid = 1'b0;
  logic          m_bready;
  logic          busy;
  logic [RS-1:0] writes_done;
  logic [RS-1:0] write_errors;

  writeback_drainer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BYTES(LB), .REGISTER_SIZE(RS)) dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush), .pattern(pattern),
    .q_value(q_value), .q_empty(q_empty), .q_full(q_full), .q_consumed(q_consumed),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .busy(busy), .writes_done(writes_done),
    .write_errors(write_errors)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RS-1:0] pat;
  } burst_t;

  logic [AW-1:0] fifo[$];
  burst_t        exp_q[$];
  logic [1:0]    bresp_plan[$];
  longint        cons_cyc[$];
  longint        cyc = 0;

  int n_assert = 0;
  int n_fail = 0;

  int aw_stall_pct = 0, w_stall_pct = 0, aw_block = 0, b_max_delay = 0;
  bit w_toggle = 0;

  burst_t        cur;
  bit            in_burst = 0, b_pending = 0, b_ack = 0, b_seen = 0;
  int            mbeat = 0, b_delay = 0;
  int            done_m = 0, err_m = 0;
  int            aw_count = 0, awv_count = 0, w_count = 0, cons_count = 0;
  logic [AW-1:0] last_awaddr = '0;
  logic          prev_awvalid = 0, prev_awready = 0, prev_wvalid = 0, prev_wready = 0, prev_cons = 0;
  logic [AW-1:0] prev_awaddr = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [RS-1:0] p);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / RS; i++) r[i*RS +: RS] = p;
    return r;
  endfunction

  function automatic logic [AW-1:0] aligned(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a % AW'(LB);
    return a - off;
  endfunction

  // Monitor: everything sampled at the falling edge, so handshakes seen here happen at the next rise.
  task automatic observe();
    logic [AW-1:0] head;
    if (prev_awvalid && !prev_awready) begin
      check("aw_valid_held", DW'(m_awvalid), DW'(1));
      check("aw_addr_stable", DW'(m_awaddr), DW'(prev_awaddr));
    end
    if (prev_wvalid && !prev_wready) check("w_valid_held", DW'(m_wvalid), DW'(1));
    if (m_wvalid) check("w_after_aw", DW'(in_burst), DW'(1));
    if (prev_cons) check("consumed_one_cycle", DW'(q_consumed), DW'(0));
    if (m_awvalid) begin
      awv_count++;
      if (aw_block > 0) aw_block--;
    end
    if (m_awvalid && m_awready) begin
      aw_count++;
      last_awaddr = m_awaddr;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL aw_unexpected: got awaddr %0h, required no burst", m_awaddr);
      end else begin
        cur = exp_q.pop_front();
        check("aw_addr", DW'(m_awaddr), DW'(cur.addr));
        check("aw_len", DW'(m_awlen), DW'(BEATS - 1));
        check("aw_size", DW'(m_awsize), DW'(4));
        check("aw_burst", DW'(m_awburst), DW'(1));
      end
      in_burst = 1;
      mbeat = 0;
    end
    if (m_wvalid && m_wready && in_burst) begin
      w_count++;
      check("w_data", m_wdata, fill(cur.pat));
      check("w_strb", DW'(m_wstrb), DW'({(DW/8){1'b1}}));
      check("w_last", DW'(m_wlast), DW'(mbeat == BEATS - 1));
      mbeat++;
      if (m_wlast) begin
        in_burst = 0;
        b_pending = 1;
        b_delay = int'($urandom_range(b_max_delay, 0));
      end
    end
    if (m_bvalid && m_bready) begin
      done_m++;
      if (m_bresp[1]) err_m++;
      b_seen = 1;
      b_ack = 1;
    end
    if (q_consumed) begin
      cons_count++;
      cons_cyc.push_back(cyc);
      check("consumed_nonempty", DW'(fifo.size() > 0), DW'(1));
      if (fifo.size() > 0) begin
        head = fifo.pop_front();
        if (head != '0) check("consumed_after_resp", DW'(b_seen), DW'(1));
      end
      b_seen = 0;
    end
    prev_awvalid = m_awvalid;
    prev_awready = m_awready;
    prev_awaddr  = m_awaddr;
    prev_wvalid  = m_wvalid;
    prev_wready  = m_wready;
    prev_cons    = q_consumed;
  endtask

  task automatic drive_slave();
    if (reset) begin
      m_awready = 0;
      m_wready = 0;
      m_bvalid = 0;
      m_bresp = 2'b00;
      return;
    end
    m_awready = (aw_block > 0) ? 1'b0 : ($urandom_range(99) >= aw_stall_pct);
    m_wready  = w_toggle ? ~m_wready : ($urandom_range(99) >= w_stall_pct);
    if (b_ack) begin
      m_bvalid = 0;
      b_ack = 0;
    end else if (b_pending && !m_bvalid) begin
      if (b_delay == 0) begin
        m_bvalid = 1;
        m_bresp = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'($urandom_range(3));
        b_pending = 0;
      end else begin
        b_delay--;
      end
    end
  endtask

  initial begin : env
    forever begin
      @(negedge clock);
      if (!reset) observe();
      @(posedge clock);
      #1;
      drive_slave();
      #1;
      q_empty = (fifo.size() == 0);
      q_full  = (fifo.size() >= DEPTH);
      q_value = (fifo.size() > 0) ? fifo[0] : '0;
    end
  end

  task automatic push(input logic [AW-1:0] a);
    burst_t b;
    @(posedge clock);
    #1;
    fifo.push_back(a);
    if (a != '0) begin
      b.addr = aligned(a);
      b.pat = pattern;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      #2;
      if (fifo.size() == 0 && !busy && !in_burst && !b_pending && !m_bvalid) begin
        ok = 1;
        break;
      end
    end
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: got fifo %0d busy %0d, required drained and idle", name, fifo.size(), busy);
    end
    check({name, "_exp_empty"}, DW'(exp_q.size()), DW'(0));
  endtask

  task automatic drain_all(input string name);
    @(posedge clock);
    #1;
    flush = 1;
    wait_idle(name);
    @(posedge clock);
    #1;
    flush = 0;
    repeat (2) @(posedge clock);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0, e0, c0, w0, awv0, edges;
    logic [AW-1:0] a;
    bit hit;

    repeat (3) @(posedge clock);
    #1;
    check("rst_awvalid", DW'(m_awvalid), DW'(0));
    check("rst_wvalid", DW'(m_wvalid), DW'(0));
    check("rst_bready", DW'(m_bready), DW'(0));
    check("rst_consumed", DW'(q_consumed), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_writes_done", DW'(writes_done), DW'(0));
    check("rst_write_errors", DW'(write_errors), DW'(0));
    reset = 0;
    enable = 1;

    // Fill to full with a zero-wait slave: back-to-back bursts.
    pattern = 32'hA5A5_A5A5;
    cons_cyc.delete();
    for (int i = 0; i < DEPTH; i++) push(40'h12_3456_7844);
    wait_idle("t1");
    check("t1_awaddr", DW'(last_awaddr), DW'(40'h12_3456_7840));
    check("t1_writes_done", DW'(writes_done), DW'(4));
    check("t1_q_empty", DW'(q_empty), DW'(1));
    check("t1_consumed_count", DW'(cons_cyc.size()), DW'(4));
    if (cons_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("t1_b2b_gap", DW'(cons_cyc[i] - cons_cyc[i-1]), DW'(4 + BEATS));

    // One entry, no flush, not full: must sit untouched until flush.
    pattern = 32'h1357_9BDF;
    awv0 = awv_count;
    c0 = cons_count;
    d0 = int'(writes_done);
    push(40'h00_0000_1000);
    repeat (50) @(negedge clock);
    check("t2_no_awvalid", DW'(awv_count - awv0), DW'(0));
    check("t2_busy_low", DW'(busy), DW'(0));
    drain_all("t2");
    check("t2_consumed", DW'(cons_count - c0), DW'(1));
    check("t2_writes_done", DW'(int'(writes_done) - d0), DW'(1));
    awv0 = awv_count;
    push(40'h00_0000_2040);
    repeat (20) @(negedge clock);
    check("t2_drain_cleared", DW'(awv_count - awv0), DW'(0));
    drain_all("t2b");

    // Address 0 is discarded without bus traffic, two edges after flush.
    push('0);
    repeat (5) @(posedge clock);
    d0 = int'(writes_done);
    awv0 = awv_count;
    @(posedge clock);
    #1;
    flush = 1;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (q_consumed) begin
        edges = k;
        break;
      end
    end
    check("t3_consume_latency", DW'(edges), DW'(2));
    wait_idle("t3");
    flush = 0;
    check("t3_writes_done", DW'(writes_done), DW'(d0));
    check("t3_no_awvalid", DW'(awv_count - awv0), DW'(0));

    // AW stalled for 10 cycles, W ready toggling.
    pattern = 32'hDEAD_BEEF;
    aw_block = 10;
    w_toggle = 1;
    w0 = w_count;
    awv0 = awv_count;
    push(40'h0F_FFFF_FFC5);
    drain_all("t4");
    check("t4_w_handshakes", DW'(w_count - w0), DW'(BEATS));
    check("t4_aw_stalled", DW'(awv_count - awv0 >= 11), DW'(1));
    w_toggle = 0;
    aw_block = 0;

    // Error responses on two of three bursts.
    pattern = 32'h0BAD_F00D;
    d0 = int'(writes_done);
    e0 = int'(write_errors);
    bresp_plan = '{2'b10, 2'b00, 2'b10};
    push(40'h00_0001_0000);
    push(40'h00_0001_0040);
    push(40'h00_0001_0080);
    drain_all("t5");
    check("t5_writes_done", DW'(int'(writes_done) - d0), DW'(3));
    check("t5_write_errors", DW'(int'(write_errors) - e0), DW'(2));

    // enable dropped mid-burst: the burst finishes, nothing new starts.
    pattern = 32'h5555_AAAA;
    w_stall_pct = 50;
    c0 = cons_count;
    push(40'h00_0002_0000);
    push(40'h00_0002_0100);
    @(posedge clock);
    #1;
    flush = 1;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      #2;
      if (in_burst) begin
        hit = 1;
        break;
      end
    end
    check("t6_burst_started", DW'(hit), DW'(1));
    @(posedge clock);
    #1;
    enable = 0;
    repeat (40) @(negedge clock);
    check("t6_one_burst", DW'(cons_count - c0), DW'(1));
    check("t6_busy_low", DW'(busy), DW'(0));
    check("t6_fifo_left", DW'(fifo.size()), DW'(1));
    enable = 1;
    wait_idle("t6");
    flush = 0;
    check("t6_all_consumed", DW'(cons_count - c0), DW'(2));

    // Randomised batches against the model.
    for (int b = 0; b < 12; b++) begin
      pattern = $urandom;
      aw_stall_pct = int'($urandom_range(60));
      w_stall_pct = int'($urandom_range(60));
      b_max_delay = int'($urandom_range(4));
      for (int i = 0; i < int'($urandom_range(DEPTH, 1)); i++) begin
        a = {8'($urandom), 32'($urandom)};
        if ($urandom_range(9) == 0) a = '0;
        push(a);
      end
      drain_all("t7");
    end
    check("t7_writes_done", DW'(writes_done), DW'(done_m));
    check("t7_write_errors", DW'(write_errors), DW'(err_m));

    // Reset while the drainer presents beat 2 of a burst.
    aw_stall_pct = 0;
    w_stall_pct = 0;
    b_max_delay = 0;
    pattern = 32'hCAFE_0001;
    push(40'h00_0003_0000);
    push(40'h00_0003_0040);
    @(posedge clock);
    #1;
    flush = 1;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      #2;
      if (in_burst && m_wvalid && (mbeat - int'(m_wready)) == 2) begin
        hit = 1;
        break;
      end
    end
    check("t8_reached_beat2", DW'(hit), DW'(1));
    reset = 1;
    #1;
    check("t8_awvalid", DW'(m_awvalid), DW'(0));
    check("t8_wvalid", DW'(m_wvalid), DW'(0));
    check("t8_consumed", DW'(q_consumed), DW'(0));
    check("t8_busy", DW'(busy), DW'(0));
    check("t8_writes_done", DW'(writes_done), DW'(0));
    check("t8_write_errors", DW'(write_errors), DW'(0));
    fifo.delete();
    exp_q.delete();
    bresp_plan.delete();
    in_burst = 0;
    b_pending = 0;
    b_ack = 0;
    b_seen = 0;
    mbeat = 0;
    done_m = 0;
    err_m = 0;
    prev_awvalid = 0;
    prev_awready = 0;
    prev_wvalid = 0;
    prev_wready = 0;
    prev_cons = 0;
    flush = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    pattern = 32'h0123_4567;
    push(40'h00_0004_0010);
    push(40'h00_0004_0050);
    push(40'h00_0004_0090);
    drain_all("t8");
    check("t8_restart_done", DW'(writes_done), DW'(3));
    check("t8_restart_errors", DW'(write_errors), DW'(err_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
